// File: rtl/vga_pkg.sv
// Shared VGA timing constants: pixel-rate divide ratios and duty-cycle helper.
package vga_pkg;

    localparam int unsigned DIV_W_DEF  = 8;

    localparam int unsigned DIV_100MHZ = 1;
    localparam int unsigned DIV_50MHZ  = 2;
    localparam int unsigned DIV_33MHZ  = 3;
    localparam int unsigned DIV_25MHZ  = 4;
    localparam int unsigned DIV_20MHZ  = 5;

    typedef enum logic [2:0] {
        ModeFull,
        ModeHalf,
        ModeThird,
        ModeVga,
        ModeFifth
    } pix_mode_e;

    function automatic int unsigned mode_ratio(pix_mode_e mode);
        int unsigned r;
        r = DIV_25MHZ;
        unique case (mode)
            ModeFull:  r = DIV_100MHZ;
            ModeHalf:  r = DIV_50MHZ;
            ModeThird: r = DIV_33MHZ;
            ModeVga:   r = DIV_25MHZ;
            ModeFifth: r = DIV_20MHZ;
            default:   r = DIV_25MHZ;
        endcase
        return r;
    endfunction

    // Number of high cycles in a period of n cycles.
    function automatic int unsigned ceil_half(int unsigned n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/vga_clk_div_prog_if.sv
// Ratio-load handshake between a mode controller (master) and the divider (slave).
interface vga_clk_div_prog_if #(
    parameter int unsigned DIV_W = 8
);
    logic [DIV_W-1:0] div_i;
    logic             div_load_i;
    logic             div_busy_o;
    logic             div_err_o;

    modport master (
        output div_i,
        output div_load_i,
        input  div_busy_o,
        input  div_err_o
    );

    modport slave (
        input  div_i,
        input  div_load_i,
        output div_busy_o,
        output div_err_o
    );
endinterface

// File: rtl/vga_div_ratio_reg.sv
// Divide-ratio register with a one-deep pending slot applied at period boundaries.
module vga_div_ratio_reg
    import vga_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DIV_DEFAULT = DIV_25MHZ
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    input  logic             apply_now_i,
    output logic [DIV_W-1:0] n_o,
    output logic [DIV_W-1:0] n_next_o,
    output logic             busy_o,
    output logic             err_o
);

    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             accept;

    always_comb begin
        accept = div_load_i && (div_i != '0) && !busy_q;
        n_d    = n_q;
        pend_d = pend_q;
        busy_d = busy_q;
        err_d  = div_load_i && !accept;
        if (busy_q && apply_now_i) begin
            n_d    = pend_q;
            busy_d = 1'b0;
        end
        // accept implies !busy_q, so this never collides with the pending apply above
        if (accept) begin
            if (apply_now_i) begin
                n_d = div_i;
            end else begin
                pend_d = div_i;
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q    <= DIV_W'(DIV_DEFAULT);
            pend_q <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            n_q    <= n_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign n_o      = n_q;
    assign n_next_o = n_d;
    assign busy_o   = busy_q;
    assign err_o    = err_q;

endmodule

// File: rtl/vga_clk_div_prog.sv
// Programmable clock divider / clock-enable generator with registered outputs.
module vga_clk_div_prog
    import vga_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DIV_DEFAULT = DIV_25MHZ
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    vga_clk_div_prog_if.slave   div_if,
    output logic                clk_o,
    output logic                clk_en_o,
    output logic [DIV_W-1:0]    phase_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             clk_en_q, clk_en_d;
    logic [DIV_W-1:0] n_cur, n_next, half;
    logic             wrap, apply_now;

    vga_div_ratio_reg #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ratio (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .div_i       (div_if.div_i),
        .div_load_i  (div_if.div_load_i),
        .apply_now_i (apply_now),
        .n_o         (n_cur),
        .n_next_o    (n_next),
        .busy_o      (div_if.div_busy_o),
        .err_o       (div_if.div_err_o)
    );

    // n_next differs from n_cur only on wrap or idle edges, so a fresh period
    // (or the idle parking position) always uses the ratio being installed.
    always_comb begin
        wrap      = en_i && (cnt_q == (n_cur - DIV_W'(1)));
        apply_now = !en_i || wrap;
        half      = DIV_W'(ceil_half(32'(n_next)));
        if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
        end else begin
            cnt_d = n_next - DIV_W'(1);
        end
        clk_d    = en_i && (cnt_d < half);
        clk_en_d = en_i && (cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= DIV_W'(DIV_DEFAULT - 1);
            clk_q    <= 1'b0;
            clk_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign clk_o    = clk_q;
    assign clk_en_o = clk_en_q;
    assign phase_o  = cnt_q;

endmodule

// File: tb/tb_vga_clk_div_prog.sv
// Scoreboard bench: directed steps queue expected outputs, a monitor compares each cycle.
module tb_vga_clk_div_prog;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic         clk_o, clk_en_o;
    logic [W-1:0] phase;

    vga_clk_div_prog_if #(.DIV_W(W)) dif ();

    vga_clk_div_prog #(
        .DIV_W       (W),
        .DIV_DEFAULT (4)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .div_if   (dif),
        .clk_o    (clk_o),
        .clk_en_o (clk_en_o),
        .phase_o  (phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         c;
        logic         e;
        logic [W-1:0] ph;
        logic         busy;
        logic         err;
    } obs_t;

    obs_t exp_q[$];
    int   tag_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_no  = 0;

    function automatic obs_t sample();
        obs_t o;
        o.c    = clk_o;
        o.e    = clk_en_o;
        o.ph   = phase;
        o.busy = dif.div_busy_o;
        o.err  = dif.div_err_o;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got clk=%0b en=%0b ph=%0d busy=%0b err=%0b, want clk=%0b en=%0b ph=%0d busy=%0b err=%0b",
                     name, got.c, got.e, got.ph, got.busy, got.err,
                     want.c, want.e, want.ph, want.busy, want.err);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic e, input logic ld, input int d,
                        input logic c, input logic ce, input int ph,
                        input logic b, input logic er);
        obs_t x;
        @(negedge clk);
        en             = e;
        dif.div_load_i = ld;
        dif.div_i      = W'(d);
        step_no++;
        x.c    = c;
        x.e    = ce;
        x.ph   = W'(ph);
        x.busy = b;
        x.err  = er;
        exp_q.push_back(x);
        tag_q.push_back(step_no);
    endtask

    initial begin : monitor
        obs_t want;
        int   t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                t    = tag_q.pop_front();
                check($sformatf("step%0d", t), sample(), want);
            end
        end
    end

    initial begin : stimulus
        obs_t rst_exp;
        rst_exp.c    = 1'b0;
        rst_exp.e    = 1'b0;
        rst_exp.ph   = W'(3);
        rst_exp.busy = 1'b0;
        rst_exp.err  = 1'b0;

        dif.div_load_i = 1'b0;
        dif.div_i      = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", sample(), rst_exp);
        rst_n = 1'b1;

        step(0, 0, 0, 0, 0, 3, 0, 0);
        // N=4 free run: 1,1,0,0
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 0, 1, 1, 0, 0, 0);
            step(1, 0, 0, 1, 0, 1, 0, 0);
            step(1, 0, 0, 0, 0, 2, 0, 0);
            step(1, 0, 0, 0, 0, 3, 0, 0);
        end
        // deferred load of 3 while phase is 1
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 1, 3, 0, 0, 2, 1, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 2, 0, 0);
        // immediate load of 4 on the N=3 wrap cycle
        step(1, 1, 4, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 2, 0, 0);
        step(1, 0, 0, 0, 0, 3, 0, 0);
        // immediate load of 5 on the N=4 wrap cycle: 1,1,1,0,0
        step(1, 1, 5, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 2, 0, 0);
        step(1, 0, 0, 0, 0, 3, 0, 0);
        step(1, 0, 0, 0, 0, 4, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        // zero ratio rejected, then 2 pending, then 7 rejected while busy
        step(1, 1, 0, 1, 0, 1, 0, 1);
        step(1, 1, 2, 1, 0, 2, 1, 0);
        step(1, 1, 7, 0, 0, 3, 1, 1);
        step(1, 0, 0, 0, 0, 4, 1, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        // back to N=4 through the pending path
        step(1, 1, 4, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 2, 0, 0);
        // idle from phase 2; a load in idle applies at once
        step(0, 0, 0, 0, 0, 3, 0, 0);
        step(0, 1, 3, 0, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0, 2, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 2, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        // pend 6, then async reset mid-period with clk_o high
        step(1, 1, 6, 1, 0, 1, 1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", sample(), rst_exp);
        en             = 1'b0;
        dif.div_load_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // default N=4 again; the pending 6 must be gone
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 2, 0, 0);
        step(1, 0, 0, 0, 0, 3, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 2, 0, 0);
        step(1, 0, 0, 0, 0, 3, 0, 0);
        // N=1: clk_o and clk_en_o stay high
        step(1, 1, 1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 1, 1, 0, 0, 0);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
